// File: rtl/serv_pkg.sv
// Shared definitions for the SERV data-bus controller:
// FSM state encoding and error-cause codes.
package serv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } dbus_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_BUS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/serv_dbus_wdog.sv
// Bus-cycle watchdog: counts stalled BUS cycles, flags expiry
// on the cycle whose increment would reach all-ones.
module serv_dbus_wdog #(
  parameter int W = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt_d     = cnt_q + 1'b1;
  assign o_expired = i_en & (&cnt_d);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serv_dbus_ctrl.sv
// SERV data-bus controller: one Wishbone classic cycle per request.
// Optional stall watchdog enabled by SERV_DBUS_TIMEOUT_EN.
module serv_dbus_ctrl
  import serv_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic        i_misalign,
  input  logic [31:0] i_dat,
  input  logic [3:0]  i_sel,
  output logic        o_ack,
  output logic        o_err,
  output logic [1:0]  o_err_cause,
  output logic [31:0] o_rdt,
  output logic        o_busy,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  dbus_state_e state_q;
  logic        ack_q;
  logic        err_q;
  logic [1:0]  cause_q;
  logic [31:0] rdt_q;
  logic        busy_q;
  logic [29:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        cyc_q;

  logic        accept;
  logic        wd_exp;
  logic        unused_adr;

  assign unused_adr = ^i_adr[1:0];
  assign accept     = (state_q == S_IDLE) & i_req & ~i_misalign;

`ifdef SERV_DBUS_TIMEOUT_EN
  logic wd_en;

  assign wd_en = (state_q == S_BUS) & ~i_wb_ack & ~i_wb_err;

  serv_dbus_wdog #(
    .W(TIMEOUT_W)
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (accept),
    .i_en     (wd_en),
    .o_expired(wd_exp)
  );
`else
  localparam int unused_tw = TIMEOUT_W;
  assign wd_exp = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cause_q <= ERR_NONE;
      rdt_q   <= '0;
      busy_q  <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_req) begin
            busy_q <= 1'b1;
            if (i_misalign) begin
              state_q <= S_RESP;
              cause_q <= ERR_MISALIGN;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_BUS;
              cause_q <= ERR_NONE;
              adr_q   <= i_adr[31:2];
              dat_q   <= i_dat;
              sel_q   <= i_sel;
              we_q    <= i_we;
              cyc_q   <= 1'b1;
            end
          end
        end
        S_BUS: begin
          // Error beats ack; read data only lands on a clean load ack.
          if (i_wb_err) begin
            state_q <= S_RESP;
            cause_q <= ERR_BUS;
            err_q   <= 1'b1;
            cyc_q   <= 1'b0;
          end else if (i_wb_ack) begin
            state_q <= S_RESP;
            cause_q <= ERR_NONE;
            ack_q   <= 1'b1;
            cyc_q   <= 1'b0;
            if (!we_q) rdt_q <= i_wb_rdt;
          end else if (wd_exp) begin
            state_q <= S_RESP;
            cause_q <= ERR_TIMEOUT;
            err_q   <= 1'b1;
            cyc_q   <= 1'b0;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_err_cause = cause_q;
  assign o_rdt       = rdt_q;
  assign o_busy      = busy_q;
  assign o_wb_adr    = {adr_q, 2'b00};
  assign o_wb_dat    = dat_q;
  assign o_wb_sel    = sel_q;
  assign o_wb_we     = we_q;
  assign o_wb_cyc    = cyc_q;

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// Directed bench for serv_dbus_ctrl; the watchdog scenario is
// exercised only when SERV_DBUS_TIMEOUT_EN is defined.
module tb_serv_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic        misalign;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        ack;
  logic        err;
  logic [1:0]  cause;
  logic [31:0] rdt;
  logic        busy;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        wb_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serv_dbus_ctrl #(
    .TIMEOUT_W(4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_we       (we),
    .i_adr      (adr),
    .i_misalign (misalign),
    .i_dat      (dat),
    .i_sel      (sel),
    .o_ack      (ack),
    .o_err      (err),
    .o_err_cause(cause),
    .o_rdt      (rdt),
    .o_busy     (busy),
    .o_wb_adr   (wb_adr),
    .o_wb_dat   (wb_dat),
    .o_wb_sel   (wb_sel),
    .o_wb_we    (wb_we),
    .o_wb_cyc   (wb_cyc),
    .i_wb_rdt   (wb_rdt),
    .i_wb_ack   (wb_ack),
    .i_wb_err   (wb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if ({ack, err, cause, busy, wb_cyc, wb_we} !== 7'd0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=0", {ack, err, cause, busy, wb_cyc, wb_we});
    end
    total++;
    if ({rdt, wb_adr, wb_dat, wb_sel} !== 100'd0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", {rdt, wb_adr, wb_dat, wb_sel});
    end
  endtask

  task automatic test_load();
    req = 1; we = 0; adr = 32'h0000_1006; sel = 4'hC; misalign = 0;
    tick();
    req = 0;
    total++;
    if (wb_cyc !== 1'b1 || wb_adr !== 32'h0000_1004 || wb_sel !== 4'hC || wb_we !== 1'b0) begin
      bad++;
      $display("FAIL load_bus got cyc=%b adr=%h sel=%h we=%b want 1 00001004 c 0", wb_cyc, wb_adr, wb_sel, wb_we);
    end
    wb_ack = 1; wb_rdt = 32'hDEAD_BEEF;
    tick();
    wb_ack = 0;
    total++;
    if (ack !== 1'b1 || err !== 1'b0 || rdt !== 32'hDEAD_BEEF || cause !== 2'd0 || wb_cyc !== 1'b0) begin
      bad++;
      $display("FAIL load_ack got ack=%b err=%b rdt=%h cause=%0d cyc=%b want 1 0 deadbeef 0 0", ack, err, rdt, cause, wb_cyc);
    end
    tick();
    total++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL load_done got ack=%b busy=%b want 0 0", ack, busy);
    end
  endtask

  task automatic test_store_waits();
    int ncyc = 0;
    req = 1; we = 1; adr = 32'h0000_2000; dat = 32'h1234_5678; sel = 4'hF; misalign = 0;
    tick();
    req = 0;
    for (int i = 1; i <= 4; i++) begin
      if (wb_cyc) ncyc++;
      if (i == 1) begin
        total++;
        if (wb_we !== 1'b1 || wb_dat !== 32'h1234_5678 || wb_sel !== 4'hF || busy !== 1'b1) begin
          bad++;
          $display("FAIL store_bus got we=%b dat=%h sel=%h busy=%b want 1 12345678 f 1", wb_we, wb_dat, wb_sel, busy);
        end
      end
      if (i == 4) wb_ack = 1;
      tick();
    end
    wb_ack = 0;
    if (wb_cyc) ncyc++;
    total++;
    if (ncyc !== 4) begin
      bad++;
      $display("FAIL store_cyc_len got=%0d want=4", ncyc);
    end
    total++;
    if (ack !== 1'b1 || rdt !== 32'hDEAD_BEEF || cause !== 2'd0) begin
      bad++;
      $display("FAIL store_ack got ack=%b rdt=%h cause=%0d want 1 deadbeef 0", ack, rdt, cause);
    end
    tick();
  endtask

  task automatic test_misalign();
    req = 1; we = 0; adr = 32'h0000_3001; misalign = 1;
    tick();
    req = 0; misalign = 0;
    total++;
    if (err !== 1'b1 || ack !== 1'b0 || cause !== 2'd1 || wb_cyc !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL misalign_err got err=%b ack=%b cause=%0d cyc=%b busy=%b want 1 0 1 0 1", err, ack, cause, wb_cyc, busy);
    end
    tick();
    total++;
    if (err !== 1'b0 || cause !== 2'd1 || wb_cyc !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL misalign_after got err=%b cause=%0d cyc=%b busy=%b want 0 1 0 0", err, cause, wb_cyc, busy);
    end
  endtask

  task automatic test_ack_err();
    req = 1; we = 0; adr = 32'h0000_4000; sel = 4'hF; misalign = 0;
    tick();
    req = 0;
    wb_ack = 1; wb_err = 1; wb_rdt = 32'h1111_1111;
    tick();
    wb_ack = 0; wb_err = 0;
    total++;
    if (err !== 1'b1 || ack !== 1'b0 || cause !== 2'd2 || rdt !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL ack_err got err=%b ack=%b cause=%0d rdt=%h want 1 0 2 deadbeef", err, ack, cause, rdt);
    end
    tick();
  endtask

`ifdef SERV_DBUS_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    req = 1; we = 0; adr = 32'h0000_5000; sel = 4'hF; misalign = 0;
    tick();
    req = 0;
    while (wb_cyc && n < 40) begin
      n++;
      tick();
    end
    total++;
    if (n !== 15) begin
      bad++;
      $display("FAIL timeout_len got=%0d want=15", n);
    end
    total++;
    if (err !== 1'b1 || ack !== 1'b0 || cause !== 2'd3) begin
      bad++;
      $display("FAIL timeout_err got err=%b ack=%b cause=%0d want 1 0 3", err, ack, cause);
    end
    tick();
    req = 1;
    tick();
    req = 0;
    wb_ack = 1; wb_rdt = 32'hCAFE_0001;
    tick();
    wb_ack = 0;
    total++;
    if (ack !== 1'b1 || rdt !== 32'hCAFE_0001 || cause !== 2'd0) begin
      bad++;
      $display("FAIL timeout_retry got ack=%b rdt=%h cause=%0d want 1 cafe0001 0", ack, rdt, cause);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_bus();
    int flags = 0;
    req = 1; we = 1; adr = 32'h0000_6008; dat = 32'hA5A5_5A5A; sel = 4'h3; misalign = 0;
    tick();
    req = 0;
    total++;
    if (wb_cyc !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_cyc got=%b want=1", wb_cyc);
    end
    #2 rst = 1;
    #1;
    total++;
    if (wb_cyc !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_async got cyc=%b busy=%b want 0 0", wb_cyc, busy);
    end
    tick();
    if (ack || err) flags++;
    rst = 0;
    tick();
    if (ack || err) flags++;
    total++;
    if ({ack, err, cause, busy, wb_cyc, wb_we, rdt, wb_adr, wb_dat, wb_sel} !== 107'd0 || flags != 0) begin
      bad++;
      $display("FAIL rst_state got flags=%0d cyc=%b adr=%h rdt=%h want all 0", flags, wb_cyc, wb_adr, rdt);
    end
    req = 1; we = 0; adr = 32'h0000_7010; sel = 4'h1;
    tick();
    req = 0;
    wb_ack = 1; wb_rdt = 32'h0BAD_F00D;
    tick();
    wb_ack = 0;
    total++;
    if (ack !== 1'b1 || rdt !== 32'h0BAD_F00D || wb_adr !== 32'h0000_7010) begin
      bad++;
      $display("FAIL rst_recover got ack=%b rdt=%h adr=%h want 1 0badf00d 00007010", ack, rdt, wb_adr);
    end
    tick();
  endtask

  initial begin
    rst = 1; req = 0; we = 0; adr = '0; misalign = 0; dat = '0; sel = '0;
    wb_rdt = '0; wb_ack = 0; wb_err = 0;
    tick();
    test_reset();
    tick();
    rst = 0;
    tick();
    test_load();
    test_store_waits();
    test_misalign();
    test_ack_err();
`ifdef SERV_DBUS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_bus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serv_dbus_ctrl.md
# serv_dbus_ctrl

Data-bus controller between the SERV load/store datapath and the external Wishbone data port. It latches a word-aligned request (address, write data, byte selects) from the core, runs exactly one Wishbone classic cycle, and returns read data with a single-cycle acknowledge that the memory interface uses to parallel-load its byte shift registers. It also rejects misaligned accesses without touching the bus and can optionally abort stalled cycles with a watchdog.

## Interface
- TIMEOUT_W, default 8: watchdog counter width. Timeout fires after 2^TIMEOUT_W − 1 wait cycles. Used only with SERV_DBUS_TIMEOUT_EN.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  core request strobe; sampled only in IDLE.
- i_we  in  1  1 = store, 0 = load.
- i_adr  in  32  byte address from core.
- i_misalign  in  1  misalignment flag from memory interface, valid with i_req.
- i_dat  in  32  store data.
- i_sel  in  4  byte lane enables.
- o_ack  out  1  one-cycle completion pulse to core.
- o_err  out  1  one-cycle error pulse to core; mutually exclusive with o_ack.
- o_err_cause  out  2  0 = none, 1 = misaligned, 2 = bus error, 3 = timeout; held until next request.
- o_rdt  out  32  registered read data, valid in the o_ack cycle, held until next load completes.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_wb_adr  out  32  {adr[31:2], 2'b00}.
- o_wb_dat  out  32  latched store data.
- o_wb_sel  out  4  latched lane enables.
- o_wb_we  out  1  latched write enable.
- o_wb_cyc  out  1  cycle/strobe (cyc and stb tied).
- i_wb_rdt  in  32  read data.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_err  in  1  slave error.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: when i_req=1 and i_misalign=0, latch adr/dat/sel/we, go BUS. When i_req=1 and i_misalign=1, go RESP with cause 1, no bus cycle.
- BUS: o_wb_cyc=1, all o_wb_* stable. On i_wb_ack: capture i_wb_rdt into o_rdt if !we (stores leave o_rdt unchanged), cause 0, go RESP. On i_wb_err: cause 2, go RESP. ack and err together: err wins, o_rdt not updated.
- RESP: one cycle. o_ack=1 if cause 0, else o_err=1. Return to IDLE.
- i_req in BUS or RESP is ignored (core holds off on o_busy); no queueing.
- o_wb_sel/o_wb_dat driven from latches in all states; the bus ignores them while cyc=0.
- Reset values: state IDLE, o_wb_cyc 0, o_ack 0, o_err 0, o_err_cause 0, o_busy 0, o_rdt 0, o_wb_adr/dat/sel/we 0, watchdog 0.
- Reset asserted mid-cycle: cyc drops asynchronously, no ack/err issued, request lost.

## Timing
- Request accepted at edge N (IDLE); cyc high from N+1.
- Zero-wait slave (ack in first BUS cycle): o_ack at N+2. Latency = 2 + wait states.
- Misaligned: o_err at N+1, cyc never asserted.
- o_ack/o_err exactly one cycle wide; next request may be accepted in the cycle after RESP (minimum 3-cycle request spacing).
- o_rdt changes only on the edge leaving BUS via ack on a load.

## Configuration
- SERV_DBUS_TIMEOUT_EN defined: watchdog counter clears on entering BUS and increments each BUS cycle without ack/err. On reaching all-ones: drop cyc, cause 3, go RESP. ack/err in the same cycle as expiry takes priority over timeout.
- Undefined: no counter, TIMEOUT_W unused, BUS waits indefinitely, cause 3 unreachable.

## Structure
- Shared package serv_pkg: state encoding (IDLE=0, BUS=1, RESP=2), error cause constants (ERR_NONE, ERR_MISALIGN, ERR_BUS, ERR_TIMEOUT).
- One sub-module serv_dbus_wdog (counter + expiry flag, enable/clear inputs), instantiated only under SERV_DBUS_TIMEOUT_EN.

## Test plan
- Load, adr 0x0000_1006, sel 0xC, slave acks after 0 waits with rdt 0xDEAD_BEEF → o_wb_adr 0x0000_1004, o_ack at request+2, o_rdt 0xDEAD_BEEF, cause 0.
- Store, dat 0x1234_5678, sel 0xF, 3 wait states → cyc high 4 cycles, o_wb_we 1, o_ack at request+5, o_rdt unchanged.
- i_req with i_misalign=1 → o_err at request+1, cause 1, cyc never high.
- Slave asserts ack and err together → o_err, cause 2, o_rdt unchanged.
- SERV_DBUS_TIMEOUT_EN, TIMEOUT_W=4, silent slave → cyc drops after 15 BUS cycles, o_err, cause 3; reissue with acking slave succeeds.
- i_rst pulsed during BUS → cyc 0 immediately, no o_ack/o_err, all outputs at reset values, next request completes normally.
